// File: rtl/repl_policy_engine.sv
// Per-set victim selection for the set-associative cache: age-counter LRU or FIFO, registered lookup.
// Define REPL_WAY_LOCK_EN to add the lock_mask port that excludes ways from victimisation.
module repl_policy_engine #(
    parameter int NUM_SETS = 64,
    parameter int ASSOC    = 4,
    parameter int POLICY   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        lookup_valid,
    input  logic [$clog2(NUM_SETS)-1:0] lookup_set,
    input  logic [ASSOC-1:0]            lookup_way_valid,
    input  logic                        update_valid,
    input  logic [$clog2(NUM_SETS)-1:0] update_set,
    input  logic [$clog2(ASSOC)-1:0]    update_way,
    input  logic                        update_is_fill,
`ifdef REPL_WAY_LOCK_EN
    input  logic [ASSOC-1:0]            lock_mask,
`endif
    output logic                        victim_valid,
    output logic [$clog2(ASSOC)-1:0]    victim_way,
    output logic                        victim_invalid,
    output logic                        victim_none
);
    localparam int WW = $clog2(ASSOC);

    generate
        if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : gBadSets
            $error("repl_policy_engine: NUM_SETS must be a power of 2 and >= 2");
        end
        if (ASSOC < 2 || (ASSOC & (ASSOC - 1)) != 0) begin : gBadAssoc
            $error("repl_policy_engine: ASSOC must be a power of 2 and >= 2");
        end
        if (POLICY != 0 && POLICY != 1) begin : gBadPolicy
            $error("repl_policy_engine: POLICY must be 0 (LRU) or 1 (FIFO)");
        end
    endgenerate

    logic [ASSOC-1:0] lockMask;
`ifdef REPL_WAY_LOCK_EN
    assign lockMask = lock_mask;
`else
    assign lockMask = '0;
`endif

    logic unusedFill;
    assign unusedFill = update_is_fill;

    // Replacement state of the looked-up set, read before any same-edge update commits.
    logic [WW-1:0] lkAges [ASSOC];
    logic [WW-1:0] lkPtr;

    generate
        if (POLICY == 0) begin : gLru
            logic [WW-1:0] age_q    [NUM_SETS][ASSOC];
            logic [WW-1:0] ageRow_d [ASSOC];
            logic [WW-1:0] hitAge;

            // Ways younger than the accessed one age by one; the accessed way becomes MRU.
            always_comb begin
                hitAge = age_q[update_set][update_way];
                for (int w = 0; w < ASSOC; w++) begin
                    ageRow_d[w] = age_q[update_set][w];
                    if (age_q[update_set][w] < hitAge) begin
                        ageRow_d[w] = age_q[update_set][w] + 1'b1;
                    end
                end
                ageRow_d[update_way] = '0;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < NUM_SETS; s++) begin
                        for (int w = 0; w < ASSOC; w++) begin
                            age_q[s][w] <= WW'(w);
                        end
                    end
                end else if (update_valid) begin
                    for (int w = 0; w < ASSOC; w++) begin
                        age_q[update_set][w] <= ageRow_d[w];
                    end
                end
            end

            always_comb begin
                for (int w = 0; w < ASSOC; w++) begin
                    lkAges[w] = age_q[lookup_set][w];
                end
            end
            assign lkPtr = '0;
        end else begin : gFifo
            logic [WW-1:0] ptr_q [NUM_SETS];
            logic [WW-1:0] ptr_d;

            // Power-of-two associativity makes the increment wrap naturally.
            assign ptr_d = update_way + 1'b1;

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < NUM_SETS; s++) begin
                        ptr_q[s] <= '0;
                    end
                end else if (update_valid && update_is_fill) begin
                    ptr_q[update_set] <= ptr_d;
                end
            end

            assign lkPtr = ptr_q[lookup_set];
            always_comb begin
                for (int w = 0; w < ASSOC; w++) begin
                    lkAges[w] = '0;
                end
            end
        end
    endgenerate

    logic [WW-1:0] victimWay_d;
    logic          victimInvalid_d;
    logic          victimNone_d;
    logic          found;
    logic [WW-1:0] bestAge;
    logic [WW-1:0] scanWay;

    // Unlocked invalid ways win first; otherwise the policy picks among unlocked ways.
    always_comb begin
        victimWay_d     = '0;
        victimInvalid_d = 1'b0;
        victimNone_d    = 1'b0;
        found           = 1'b0;
        bestAge         = '0;
        scanWay         = '0;
        for (int w = 0; w < ASSOC; w++) begin
            if (!found && !lookup_way_valid[w] && !lockMask[w]) begin
                victimWay_d     = WW'(w);
                victimInvalid_d = 1'b1;
                found           = 1'b1;
            end
        end
        if (!found) begin
            if (&lockMask) begin
                victimNone_d = 1'b1;
            end else if (POLICY == 0) begin
                for (int w = 0; w < ASSOC; w++) begin
                    if (!lockMask[w] && (!found || lkAges[w] > bestAge)) begin
                        bestAge     = lkAges[w];
                        victimWay_d = WW'(w);
                        found       = 1'b1;
                    end
                end
            end else begin
                for (int k = 0; k < ASSOC; k++) begin
                    scanWay = lkPtr + WW'(k);
                    if (!found && !lockMask[scanWay]) begin
                        victimWay_d = scanWay;
                        found       = 1'b1;
                    end
                end
            end
        end
    end

    logic          victimValid_q;
    logic [WW-1:0] victimWay_q;
    logic          victimInvalid_q;
    logic          victimNone_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            victimValid_q   <= 1'b0;
            victimWay_q     <= '0;
            victimInvalid_q <= 1'b0;
            victimNone_q    <= 1'b0;
        end else begin
            victimValid_q <= lookup_valid;
            if (lookup_valid) begin
                victimWay_q     <= victimWay_d;
                victimInvalid_q <= victimInvalid_d;
                victimNone_q    <= victimNone_d;
            end
        end
    end

    assign victim_valid   = victimValid_q;
    assign victim_way     = victimWay_q;
    assign victim_invalid = victimInvalid_q;
    assign victim_none    = victimNone_q;

endmodule

// File: tb/tb_repl_policy_engine.sv
// Randomised self-checking bench: LRU and FIFO instances share stimulus and are compared
// against a recency-list / round-robin reference model.
module tb_repl_policy_engine;
    localparam int NS = 8;
    localparam int A  = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       lookupValid;
    logic [2:0] lookupSet;
    logic [3:0] lookupWayValid;
    logic       updateValid;
    logic [2:0] updateSet;
    logic [1:0] updateWay;
    logic       updateIsFill;
    logic [3:0] lockMask;

    logic       lruValid, lruInvalid, lruNone;
    logic [1:0] lruWay;
    logic       fifoValid, fifoInvalid, fifoNone;
    logic [1:0] fifoWay;

    always #5 clk = ~clk;

    repl_policy_engine #(.NUM_SETS(NS), .ASSOC(A), .POLICY(0)) dutLru (
        .clk(clk), .reset(reset),
        .lookup_valid(lookupValid), .lookup_set(lookupSet), .lookup_way_valid(lookupWayValid),
        .update_valid(updateValid), .update_set(updateSet), .update_way(updateWay),
        .update_is_fill(updateIsFill),
`ifdef REPL_WAY_LOCK_EN
        .lock_mask(lockMask),
`endif
        .victim_valid(lruValid), .victim_way(lruWay),
        .victim_invalid(lruInvalid), .victim_none(lruNone)
    );

    repl_policy_engine #(.NUM_SETS(NS), .ASSOC(A), .POLICY(1)) dutFifo (
        .clk(clk), .reset(reset),
        .lookup_valid(lookupValid), .lookup_set(lookupSet), .lookup_way_valid(lookupWayValid),
        .update_valid(updateValid), .update_set(updateSet), .update_way(updateWay),
        .update_is_fill(updateIsFill),
`ifdef REPL_WAY_LOCK_EN
        .lock_mask(lockMask),
`endif
        .victim_valid(fifoValid), .victim_way(fifoWay),
        .victim_invalid(fifoInvalid), .victim_none(fifoNone)
    );

    // Model: per set, ways ordered most- to least-recently used; FIFO next-fill pointer.
    int mruList [NS][A];
    int fifoPtr [NS];
    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k < A; k++) mruList[s][k] = k;
            fifoPtr[s] = 0;
        end
    endfunction

    function automatic void modelUpdate(input int s, input int w, input bit fill);
        int pos = 0;
        for (int k = 0; k < A; k++) if (mruList[s][k] == w) pos = k;
        for (int k = pos; k > 0; k--) mruList[s][k] = mruList[s][k-1];
        mruList[s][0] = w;
        if (fill) fifoPtr[s] = (w + 1) % A;
    endfunction

    function automatic int firstInvalid(input logic [3:0] valid, input logic [3:0] lock);
        for (int w = 0; w < A; w++) if (!valid[w] && !lock[w]) return w;
        return -1;
    endfunction

    function automatic int lruOldest(input int s, input logic [3:0] lock);
        for (int k = A - 1; k >= 0; k--) if (!lock[mruList[s][k]]) return mruList[s][k];
        return 0;
    endfunction

    function automatic int fifoNext(input int s, input logic [3:0] lock);
        for (int k = 0; k < A; k++) if (!lock[(fifoPtr[s] + k) % A]) return (fifoPtr[s] + k) % A;
        return 0;
    endfunction

    task automatic applyStimulus(input bit lv, input int ls, input logic [3:0] lwv,
                                 input bit uv, input int us, input int uw, input bit fill,
                                 input logic [3:0] lk);
        int  inv, wayL, wayF;
        bit  none;
        lookupValid    = lv;
        lookupSet      = 3'(ls);
        lookupWayValid = lwv;
        updateValid    = uv;
        updateSet      = 3'(us);
        updateWay      = 2'(uw);
        updateIsFill   = fill;
        lockMask       = lk;
        inv  = firstInvalid(lwv, lk);
        none = (lk == 4'hF);
        wayL = none ? 0 : ((inv >= 0) ? inv : lruOldest(ls, lk));
        wayF = none ? 0 : ((inv >= 0) ? inv : fifoNext(ls, lk));
        if (uv) modelUpdate(us, uw, fill);
        @(posedge clk);
        #1;
        lookupValid = 1'b0;
        updateValid = 1'b0;
        checkOutput("lruValid", 32'(lruValid), 32'(lv));
        checkOutput("fifoValid", 32'(fifoValid), 32'(lv));
        if (lv) begin
            checkOutput("lruWay", 32'(lruWay), 32'(wayL));
            checkOutput("lruInvalid", 32'(lruInvalid), 32'(inv >= 0));
            checkOutput("lruNone", 32'(lruNone), 32'(none));
            checkOutput("fifoWay", 32'(fifoWay), 32'(wayF));
            checkOutput("fifoInvalid", 32'(fifoInvalid), 32'(inv >= 0));
            checkOutput("fifoNone", 32'(fifoNone), 32'(none));
        end
    endtask

    task automatic doReset(input bit lookupDuring);
        reset          = 1'b1;
        lookupValid    = lookupDuring;
        lookupSet      = 3'd0;
        lookupWayValid = 4'hF;
        updateValid    = 1'b0;
        lockMask       = 4'h0;
        modelReset();
        @(posedge clk);
        #1;
        reset       = 1'b0;
        lookupValid = 1'b0;
        checkOutput("rstLruValid", 32'(lruValid), 32'd0);
        checkOutput("rstFifoValid", 32'(fifoValid), 32'd0);
        checkOutput("rstLruWay", 32'(lruWay), 32'd0);
        checkOutput("rstLruInvalid", 32'(lruInvalid), 32'd0);
        checkOutput("rstLruNone", 32'(lruNone), 32'd0);
    endtask

    initial begin
        logic [3:0] lwv, lk;
        int ls, us;
        reset = 1'b1; lookupValid = 1'b0; lookupSet = '0; lookupWayValid = 4'hF;
        updateValid = 1'b0; updateSet = '0; updateWay = '0; updateIsFill = 1'b0; lockMask = 4'h0;
        doReset(1'b0);

        applyStimulus(1, 2, 4'hF, 0, 0, 0, 0, 4'h0);
        checkOutput("tpResetLru", 32'(lruWay), 32'd3);
        checkOutput("tpResetFifo", 32'(fifoWay), 32'd0);

        for (int w = 3; w >= 0; w--) applyStimulus(0, 0, 4'hF, 1, 0, w, 0, 4'h0);
        applyStimulus(1, 0, 4'hF, 0, 0, 0, 0, 4'h0);
        checkOutput("tpLruOrder", 32'(lruWay), 32'd3);
        applyStimulus(0, 0, 4'hF, 1, 0, 3, 0, 4'h0);
        applyStimulus(1, 0, 4'hF, 0, 0, 0, 0, 4'h0);
        checkOutput("tpLruAfterHit", 32'(lruWay), 32'd2);

        applyStimulus(1, 0, 4'b1011, 0, 0, 0, 0, 4'h0);
        checkOutput("tpInvalidWay", 32'(lruWay), 32'd2);
        checkOutput("tpInvalidFlag", 32'(lruInvalid), 32'd1);

        applyStimulus(0, 1, 4'hF, 1, 1, 3, 1, 4'h0);
        applyStimulus(1, 1, 4'hF, 0, 0, 0, 0, 4'h0);
        checkOutput("tpFifoWrap", 32'(fifoWay), 32'd0);
        applyStimulus(0, 1, 4'hF, 1, 1, 1, 0, 4'h0);
        applyStimulus(1, 1, 4'hF, 0, 0, 0, 0, 4'h0);
        checkOutput("tpFifoHitIgnored", 32'(fifoWay), 32'd0);

        applyStimulus(1, 5, 4'hF, 1, 5, 3, 0, 4'h0);
        checkOutput("tpCollision", 32'(lruWay), 32'd3);
        applyStimulus(1, 5, 4'hF, 0, 0, 0, 0, 4'h0);
        checkOutput("tpAfterCollision", 32'(lruWay), 32'd2);

        applyStimulus(1, 4, 4'hF, 0, 0, 0, 0, 4'h0);
        doReset(1'b1);

`ifdef REPL_WAY_LOCK_EN
        applyStimulus(1, 3, 4'hF, 0, 0, 0, 0, 4'b1000);
        checkOutput("tpLockOne", 32'(lruWay), 32'd2);
        applyStimulus(1, 3, 4'hF, 0, 0, 0, 0, 4'b1111);
        checkOutput("tpLockAllNone", 32'(lruNone), 32'd1);
        checkOutput("tpLockAllWay", 32'(lruWay), 32'd0);
`endif

        for (int i = 0; i < 600; i++) begin
            ls  = $urandom_range(0, NS - 1);
            us  = ($urandom_range(0, 3) == 0) ? ls : $urandom_range(0, NS - 1);
            lwv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
`ifdef REPL_WAY_LOCK_EN
            lk  = ($urandom_range(0, 9) == 0) ? 4'hF :
                  (($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0);
`else
            lk  = 4'h0;
`endif
            applyStimulus($urandom_range(0, 9) < 7, ls, lwv,
                          $urandom_range(0, 9) < 7, us, $urandom_range(0, A - 1),
                          $urandom_range(0, 1) == 1, lk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
